// File: rtl/lsu_axil_master_if.sv
// AXI-Lite bus between the LSU initiator and the data-memory slave.
interface lsu_axil_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic                  bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic                  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/lsu_axil_master.sv
// AXI-Lite initiator for the LSU: one outstanding load or store at a time,
// completion reported to the core as a single-cycle rsp_valid pulse.
module lsu_axil_master #(
  parameter int          ADDR_W = 12,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_resp,
  lsu_axil_master_if.master   axi
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_e;

  state_e state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   aw_hs, w_hs;
  logic   accept, rsp_fire;

  assign aw_hs      = axi.awvalid && axi.awready;
  assign w_hs       = axi.wvalid && axi.wready;
  assign axi.awprot = PROT;
  assign axi.arprot = PROT;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = req_we ? WRITE : RADDR;
        end
      end
      WRITE: begin
        // The two channels complete independently, in either order.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (axi.bvalid) begin
          state_d  = IDLE;
          rsp_fire = 1'b1;
        end
      end
      RADDR: begin
        if (axi.arready) state_d = RDATA;
      end
      RDATA: begin
        if (axi.rvalid) begin
          state_d  = IDLE;
          rsp_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All bus controls are registered from the next state, so each valid/ready
  // is a clean flop output and drops the cycle after its own handshake.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= 1'b0;
      rsp_rdata   <= '0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.araddr  <= '0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready   <= (state_d == IDLE);
      rsp_valid   <= rsp_fire;
      axi.awvalid <= (state_d == WRITE) && !aw_done_d;
      axi.wvalid  <= (state_d == WRITE) && !w_done_d;
      axi.bready  <= (state_d == WRESP);
      axi.arvalid <= (state_d == RADDR);
      axi.rready  <= (state_d == RDATA);

      if (accept) begin
        if (req_we) begin
          axi.awaddr <= req_addr;
          axi.wdata  <= req_wdata;
          axi.wstrb  <= req_wstrb;
        end else begin
          axi.araddr <= req_addr;
        end
      end

      if (state_q == WRESP && axi.bvalid) rsp_resp <= axi.bresp;
      if (state_q == RDATA && axi.rvalid) begin
        rsp_rdata <= axi.rdata;
        rsp_resp  <= axi.rresp;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// Bench for lsu_axil_master: a schedule-driven AXI-Lite slave plus a timeline
// model that predicts every output of the initiator on every cycle.
module tb_lsu_axil_master;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_resp;
  logic [31:0] rsp_rdata;

  lsu_axil_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  lsu_axil_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT(3'b000)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (axi.master)
  );

  // One accepted request, described by the cycles at which each handshake
  // and the response must happen.
  typedef struct {
    bit          valid;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          resp;
    logic [31:0] rdata;
    int          t0, t_aw, t_w, t_bs, t_b, t_ar, t_r, t_rsp;
  } txn_t;

  txn_t        cur;
  int          cyc, checks, errors;
  bit          rst_flag;
  logic [31:0] model_mem [1024];
  logic [31:0] slave_mem [1024];
  logic [31:0] model_rdata;
  logic        model_resp;
  int          aw_cycles, w_cycles, ar_cycles, rsp_count, last_rsp_cyc, prev_rsp_cyc;
  logic [11:0] aw_cap, ar_cap;
  logic [31:0] wd_cap;
  logic [3:0]  ws_cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit exp_bready(input int c);
    return cur.valid && cur.we && c > cur.t_bs && c <= cur.t_b;
  endfunction

  function automatic bit exp_rready(input int c);
    return cur.valid && !cur.we && c > cur.t_ar && c <= cur.t_r;
  endfunction

  function automatic bit model_idle();
    return reset && !rst_flag && (!cur.valid || cyc >= cur.t_rsp);
  endfunction

  task automatic compare_cycle();
    bit e_aw, e_w, e_b, e_ar, e_r, e_rsp, e_rdy;
    if (cur.valid && cyc == cur.t_rsp) begin
      model_resp = cur.resp;
      if (cur.we) model_mem[cur.addr[11:2]] = merge(model_mem[cur.addr[11:2]], cur.wdata, cur.wstrb);
      else        model_rdata = cur.rdata;
    end
    e_aw  = cur.valid && cur.we && cyc > cur.t0 && cyc <= cur.t_aw;
    e_w   = cur.valid && cur.we && cyc > cur.t0 && cyc <= cur.t_w;
    e_ar  = cur.valid && !cur.we && cyc > cur.t0 && cyc <= cur.t_ar;
    e_b   = exp_bready(cyc);
    e_r   = exp_rready(cyc);
    e_rsp = cur.valid && cyc == cur.t_rsp;
    e_rdy = !rst_flag && !(cur.valid && cyc > cur.t0 && cyc < cur.t_rsp);

    check("req_ready", 32'(req_ready),   32'(e_rdy));
    check("awvalid",   32'(axi.awvalid), 32'(e_aw));
    check("wvalid",    32'(axi.wvalid),  32'(e_w));
    check("bready",    32'(axi.bready),  32'(e_b));
    check("arvalid",   32'(axi.arvalid), 32'(e_ar));
    check("rready",    32'(axi.rready),  32'(e_r));
    check("rsp_valid", 32'(rsp_valid),   32'(e_rsp));
    check("rsp_rdata", rsp_rdata,        model_rdata);
    check("rsp_resp",  32'(rsp_resp),    32'(model_resp));
    check("prot",      32'({axi.awprot, axi.arprot}), 32'(6'b0));
    if (e_aw) check("awaddr", 32'(axi.awaddr), 32'(cur.addr));
    if (e_w) begin
      check("wdata", axi.wdata,       cur.wdata);
      check("wstrb", 32'(axi.wstrb),  32'(cur.wstrb));
    end
    if (e_ar) check("araddr", 32'(axi.araddr), 32'(cur.addr));
    if (rst_flag) begin
      check("rst_payload", {axi.awaddr, axi.wstrb, 16'h0}, 32'h0);
      check("rst_araddr",  32'(axi.araddr), 32'h0);
      check("rst_wdata",   axi.wdata,       32'h0);
    end

    if (axi.awvalid) aw_cycles++;
    if (axi.wvalid)  w_cycles++;
    if (axi.arvalid) ar_cycles++;
    if (rsp_valid) begin
      rsp_count++;
      prev_rsp_cyc = last_rsp_cyc;
      last_rsp_cyc = cyc;
    end
  endtask

  // Model and comparison: outputs of cycle c are sampled 1 ns after its edge.
  always @(posedge clk) begin
    cyc++;
    rst_flag = !reset;
    if (rst_flag) begin
      cur.valid   = 1'b0;
      model_rdata = '0;
      model_resp  = 1'b0;
    end
    #1;
    compare_cycle();
  end

  // Slave data path: captures are taken from pre-edge bus values.
  always @(posedge clk) begin
    if (axi.awvalid && axi.awready) aw_cap = axi.awaddr;
    if (axi.wvalid && axi.wready) begin
      wd_cap = axi.wdata;
      ws_cap = axi.wstrb;
    end
    if (axi.arvalid && axi.arready) ar_cap = axi.araddr;
    if (reset && axi.bvalid && axi.bready)
      slave_mem[aw_cap[11:2]] = merge(slave_mem[aw_cap[11:2]], wd_cap, ws_cap);
  end

  // Slave handshakes follow the schedule; bvalid/rvalid also glitch at random
  // whenever the initiator must not be listening.
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid  = 1'b0; axi.bresp  = 1'b0;
    axi.rvalid  = 1'b0; axi.rresp  = 1'b0; axi.rdata = '0;
    forever begin
      @(negedge clk);
      axi.awready = cur.valid && cur.we && cyc == cur.t_aw;
      axi.wready  = cur.valid && cur.we && cyc == cur.t_w;
      axi.arready = cur.valid && !cur.we && cyc == cur.t_ar;
      if (cur.valid && cur.we && cyc == cur.t_b) begin
        axi.bvalid = 1'b1;
        axi.bresp  = cur.resp;
      end else if (!exp_bready(cyc)) begin
        axi.bvalid = 1'($urandom_range(0, 1));
        axi.bresp  = 1'($urandom_range(0, 1));
      end else begin
        axi.bvalid = 1'b0;
        axi.bresp  = 1'b0;
      end
      if (cur.valid && !cur.we && cyc == cur.t_r) begin
        axi.rvalid = 1'b1;
        axi.rdata  = slave_mem[ar_cap[11:2]];
        axi.rresp  = cur.resp;
      end else if (!exp_rready(cyc)) begin
        axi.rvalid = 1'($urandom_range(0, 1));
        axi.rdata  = $urandom;
        axi.rresp  = 1'($urandom_range(0, 1));
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        axi.rresp  = 1'b0;
      end
    end
  end

  // For stores d1/d2/d3 delay awready/wready/bvalid; for loads d1/d2 delay arready/rvalid.
  task automatic issue(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input int d1, input int d2, input int d3,
                       input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = hold;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    while (!model_idle() && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      timeout("issue_wait");
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1;
    cur.valid = 1'b1;
    cur.we    = we;
    cur.addr  = addr;
    cur.wdata = wd;
    cur.wstrb = ws;
    cur.resp  = 1'($urandom_range(0, 1));
    cur.rdata = we ? 32'h0 : model_mem[addr[11:2]];
    cur.t0    = cyc;
    if (we) begin
      cur.t_aw  = cyc + 1 + d1;
      cur.t_w   = cyc + 1 + d2;
      cur.t_bs  = (cur.t_aw > cur.t_w) ? cur.t_aw : cur.t_w;
      cur.t_b   = cur.t_bs + 1 + d3;
      cur.t_rsp = cur.t_b + 1;
    end else begin
      cur.t_ar  = cyc + 1 + d1;
      cur.t_r   = cur.t_ar + 1 + d2;
      cur.t_rsp = cur.t_r + 1;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (!model_idle() && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) timeout("wait_idle");
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
  endfunction

  initial begin
    int t0, n0;
    logic [31:0] v;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      model_mem[i] = v;
      slave_mem[i] = v;
    end
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'h1);

    // Zero-wait store.
    aw_cycles = 0; w_cycles = 0;
    issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
    t0 = cur.t0;
    wait_idle();
    check("store_latency", 32'(last_rsp_cyc - t0), 32'd3);
    check("store_aw_cycles", 32'(aw_cycles), 32'd1);

    // Load after store.
    issue(1'b0, 12'h010, 32'h0, 4'h0, 0, 0, 0, 1'b0);
    t0 = cur.t0;
    wait_idle();
    check("load_latency", 32'(last_rsp_cyc - t0), 32'd3);
    check("load_rdata", rsp_rdata, 32'hDEADBEEF);

    // Split write handshakes.
    aw_cycles = 0; w_cycles = 0; n0 = rsp_count;
    issue(1'b1, 12'h020, 32'hA5A55A5A, 4'h3, 3, 0, 0, 1'b0);
    wait_idle();
    check("split_aw_cycles", 32'(aw_cycles), 32'd4);
    check("split_w_cycles", 32'(w_cycles), 32'd1);
    check("split_rsp_count", 32'(rsp_count - n0), 32'd1);

    // Back-to-back store then load with req_valid held.
    n0 = rsp_count;
    issue(1'b1, 12'h004, 32'h12345678, 4'hF, 0, 0, 0, 1'b0);
    issue(1'b0, 12'h004, 32'h0, 4'h0, 0, 0, 0, 1'b1);
    wait_idle();
    check("b2b_rsp_count", 32'(rsp_count - n0), 32'd2);
    check("b2b_rsp_spacing", 32'(last_rsp_cyc - prev_rsp_cyc), 32'd3);
    check("b2b_rdata", rsp_rdata, 32'h12345678);

    // Read backpressure.
    ar_cycles = 0;
    issue(1'b0, 12'h020, 32'h0, 4'h0, 5, 5, 0, 1'b0);
    t0 = cur.t0;
    wait_idle();
    check("bp_ar_cycles", 32'(ar_cycles), 32'd6);
    check("bp_latency", 32'(last_rsp_cyc - t0), 32'd13);

    // Reset while in WRITE.
    n0 = rsp_count;
    issue(1'b1, 12'h030, 32'hCAFEF00D, 4'hF, 4, 4, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_awvalid", 32'({axi.awvalid, axi.wvalid}), 32'h0);
    check("mid_reset_req_ready", 32'(req_ready), 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_reset_no_rsp", 32'(rsp_count - n0), 32'h0);
    issue(1'b1, 12'h030, 32'h0BADF00D, 4'hF, 0, 0, 0, 1'b0);
    issue(1'b0, 12'h030, 32'h0, 4'h0, 0, 0, 0, 1'b0);
    wait_idle();
    check("after_reset_rdata", rsp_rdata, 32'h0BADF00D);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) wait_idle();
      issue(1'($urandom_range(0, 1)), 12'h100 + 12'(4 * $urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)),
            pick_delay(), pick_delay(), pick_delay(), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/lsu_axil_master.md
# lsu_axil_master

AXI-Lite initiator that turns single load/store requests from the core's load/store unit into AXI-Lite read or write transactions toward the data-memory slave. It sits between the LSU and the data-memory AXI-Lite port. It handles one outstanding transaction at a time and returns a single-cycle response pulse to the core carrying the read data and the response bit.

## Interface
- ADDR_W, 12, AXI/request address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- PROT, 3'b000, constant driven on awprot/arprot
- clk  in  1  clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store (write), 0 = load (read)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_wstrb  in  DATA_W/8  store byte enables
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  DATA_W  load data; holds last captured value
- rsp_resp  out  1  bresp/rresp bit of the completed transaction, forwarded uninterpreted
- awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_W/3  write address channel
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel
- bvalid/bready/bresp  in/out/in  1/1/1  write response channel
- arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_W/3  read address channel
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/1  read data channel

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE: req_ready=1. On req_valid&&req_ready, register addr/wdata/wstrb. Go to WRITE if req_we=1, otherwise RADDR.
- WRITE: awvalid and wvalid are both high on entry. Each is handshaken independently and deasserts the cycle after its own handshake; aw_done/w_done flags track completion. Either order, or both in the same cycle, is legal. Go to WRESP when both are done.
- WRESP: bready=1. On bvalid: latch bresp into rsp_resp, go to IDLE, rsp_valid=1 next cycle.
- RADDR: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid: latch rdata into rsp_rdata and rresp into rsp_resp, go to IDLE, rsp_valid=1 next cycle.
- Payload stability: awaddr/wdata/wstrb/araddr stay stable while their valid is high. No valid deasserts before its handshake.
- A store with wstrb=0 is still issued on the bus.
- awprot = arprot = PROT at all times.
- Writes leave rsp_rdata unchanged.

## Timing
- All bus outputs and rsp_* are registered.
- Reset (reset=0 at a clock edge) gives: state IDLE, all of the following 0: req_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_resp, awaddr, araddr, wdata, wstrb, rsp_rdata. req_ready becomes 1 the first cycle after reset deasserts.
- Reset mid-transaction: abandon the transaction immediately, drop all valids/readies, emit no rsp_valid.
- Against a zero-wait slave, with request accepted at cycle 0:
  - Write: aw/w handshake at cycle 1, b handshake at cycle 2, rsp_valid at cycle 3.
  - Read: ar handshake at cycle 1, r handshake at cycle 2, rsp_valid at cycle 3.
- The rsp_valid cycle is an IDLE cycle. req_ready=1 in that cycle, so a back-to-back request is accepted there, giving 3-cycle throughput.
- req_ready=0 from the cycle after acceptance until the state returns to IDLE.
- bvalid/rvalid seen outside WRESP/RDATA are ignored (bready/rready are low).

## Test plan
- Zero-wait store: addr 0x010, wdata 0xDEADBEEF, wstrb 4'hF -> awaddr=0x010 and wvalid in cycle 1, bready in cycle 2, rsp_valid in cycle 3 with rsp_resp equal to the slave bresp.
- Load after store: read 0x010 -> araddr=0x010, rsp_rdata=0xDEADBEEF at rsp_valid, 3 cycles after acceptance.
- Split write handshakes: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles with awaddr stable, single b handshake, exactly one rsp_valid.
- Back-to-back: store 0x004 then load 0x004 with req_valid held -> second request accepted in the first request's rsp_valid cycle; 2 rsp_valid pulses 3 cycles apart.
- Backpressure: arready and rvalid each delayed 5 cycles -> arvalid/rready held, req_ready=0 throughout, rsp_valid only after the r handshake.
- Reset mid-write (reset=0 while in WRITE) -> the next cycle shows all valids 0 and req_ready 0; no rsp_valid; a normal store completes after reset is released.
